instr_fetch: RTL and testbench

- Instruction-side counterpart to the MIPS-subset decoder: holds the program counter and the instruction memory, and drives `instr` into the decoder.
- Consumes the decoder's control outputs (`pcSrcCtrl`, `bneCtrl`, `jAddr`, `imm`), plus the ALU zero flag and the rs register value, to compute the next PC each cycle.
- Supplies `pcPlus4` for the JAL link write-back path.
- Includes a run/halt state machine and a loader write port for the instruction memory.

---
 rtl/instr_fetch_if.sv | 34 +++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: next-PC controls from decode/execute, loader write port,
// and the instruction/PC outputs back to the decoder.
interface instr_fetch_if #(
    parameter int unsigned AW = 10
);
    logic          stall;
    logic [1:0]    pcSrcCtrl;
    logic          bneCtrl;
    logic          zero;
    logic [25:0]   jAddr;
    logic [31:0]   imm;
    logic [31:0]   regA;
    logic          imWe;
    logic [AW-1:0] imWAddr;
    logic [31:0]   imWData;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [31:0]   pcPlus4;
    logic          halted;

    // Driver of controls and loader writes (decoder/datapath/testbench).
    modport master (
        output stall, pcSrcCtrl, bneCtrl, zero, jAddr, imm, regA,
        output imWe, imWAddr, imWData,
        input  instr, pc, pcPlus4, halted
    );

    // The fetch unit itself.
    modport slave (
        input  stall, pcSrcCtrl, bneCtrl, zero, jAddr, imm, regA,
        input  imWe, imWAddr, imWData,
        output instr, pc, pcPlus4, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, next-PC select, run/halt FSM and the
// instruction memory with a loader write port.
module instr_fetch #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned AW       = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rstN,
    instr_fetch_if.slave  bus
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] cand_pc;
    logic        taken;
    logic        cand_bad;

    logic [31:0] imem [DEPTH];

    // Address lies beyond the last memory word (DEPTH is a power of two).
    function automatic logic out_of_range(input logic [31:0] addr);
        return (addr >> (AW + 2)) != 32'd0;
    endfunction

    // Sequential PC, shared by the sequential path, jump region and branch base.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
    end

    // Candidate next PC and the halt condition it would trigger.
    always_comb begin
        taken   = bus.zero ^ bus.bneCtrl;
        cand_pc = pc_plus4;
        case (bus.pcSrcCtrl)
            2'd0:    cand_pc = pc_plus4;
            2'd1:    cand_pc = {pc_plus4[31:28], bus.jAddr, 2'b00};
            2'd2:    cand_pc = bus.regA;
            2'd3:    cand_pc = taken ? (pc_plus4 + (bus.imm << 2)) : pc_plus4;
            default: cand_pc = pc_plus4;
        endcase
        // Misalignment is only reachable through JR.
        cand_bad = (cand_pc[1:0] != 2'b00) || out_of_range(cand_pc);
    end

    // State and PC registers; reset overrides stall, branch and halt.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state: a bad candidate halts and leaves the PC on the last valid fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StRun: begin
                if (!bus.stall) begin
                    if (cand_bad) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = cand_pc;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StRun;
        endcase
    end

    // Outputs: halted feeds a NOP (all-zero word) to the decoder.
    always_comb begin
        bus.halted  = (state_q == StHalt);
        bus.pc      = pc_q;
        bus.pcPlus4 = pc_plus4;
        if (bus.halted || out_of_range(pc_q)) begin
            bus.instr = 32'h0;
        end else begin
            bus.instr = imem[pc_q[AW+1:2]];
        end
    end

    // Loader write port, active in any state including reset; no read bypass.
    always_ff @(posedge clk) begin
        if (bus.imWe) begin
            imem[bus.imWAddr] <= bus.imWData;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int unsigned Depth = 1024;
    localparam int unsigned Aw    = 10;

    typedef struct {
        logic          rst_n;
        logic          stall;
        logic [1:0]    src;
        logic          bne;
        logic          zero;
        logic [25:0]   jaddr;
        logic [31:0]   imm;
        logic [31:0]   rega;
        logic          we;
        logic [Aw-1:0] waddr;
        logic [31:0]   wdata;
        logic [31:0]   exp_pc;
        logic          exp_halted;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic [31:0] instr;
        logic [31:0] pp4;
    } exp_t;

    logic clk = 1'b0;
    logic rstN;

    instr_fetch_if #(.AW(Aw)) bus ();

    instr_fetch #(
        .DEPTH    (Depth),
        .AW       (Aw),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] model_mem [Depth];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl [20];

    function automatic vec_t mk(
        input logic rst_n, input logic stall, input logic [1:0] src,
        input logic bne, input logic zero, input logic [25:0] jaddr,
        input logic [31:0] imm, input logic [31:0] rega, input logic we,
        input logic [Aw-1:0] waddr, input logic [31:0] wdata,
        input logic [31:0] exp_pc, input logic exp_halted);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.src = src; v.bne = bne; v.zero = zero;
        v.jaddr = jaddr; v.imm = imm; v.rega = rega; v.we = we; v.waddr = waddr;
        v.wdata = wdata; v.exp_pc = exp_pc; v.exp_halted = exp_halted;
        return v;
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] p, input logic h);
        logic [Aw-1:0] idx;
        if (h || p >= 32'(Depth * 4)) return 32'h0;
        idx = p[Aw+1:2];
        return model_mem[idx];
    endfunction

    task automatic drive(input vec_t v);
        rstN          = v.rst_n;
        bus.stall     = v.stall;
        bus.pcSrcCtrl = v.src;
        bus.bneCtrl   = v.bne;
        bus.zero      = v.zero;
        bus.jAddr     = v.jaddr;
        bus.imm       = v.imm;
        bus.regA      = v.rega;
        bus.imWe      = v.we;
        bus.imWAddr   = v.waddr;
        bus.imWData   = v.wdata;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one vector, queue its expectation, then check one edge later.
    task automatic apply(input vec_t v);
        exp_t e;
        drive(v);
        if (v.we) model_mem[v.waddr] = v.wdata;
        e.pc     = v.exp_pc;
        e.halted = v.exp_halted;
        e.instr  = model_instr(v.exp_pc, v.exp_halted);
        e.pp4    = v.exp_pc + 32'd4;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            cmp("pc", bus.pc, e.pc);
            cmp("halted", {31'b0, bus.halted}, {31'b0, e.halted});
            cmp("instr", bus.instr, e.instr);
            cmp("pcPlus4", bus.pcPlus4, e.pp4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        drive(mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0, 1'b0, '0, 32'd0,
                 32'd0, 1'b0));
        // Loader fills the whole memory while reset is held.
        for (int i = 0; i < int'(Depth); i++) begin
            case (i)
                0:       w = 32'h8C01_0004;
                1:       w = 32'hAC01_0008;
                2:       w = 32'h2002_0005;
                default: w = 32'hA500_0000 | 32'(i * 7);
            endcase
            bus.imWe    = 1'b1;
            bus.imWAddr = Aw'(i);
            bus.imWData = w;
            model_mem[i] = w;
            @(posedge clk);
            #1;
        end

        tbl[0]  = mk(0, 0, 0, 0, 0, 26'd0,  32'd0,         32'd0,  0, '0, 32'd0,  32'h00, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 26'd0,  32'd0,         32'd0,  0, '0, 32'd0,  32'h04, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 26'd0,  32'd0,         32'd0,  0, '0, 32'd0,  32'h08, 0);
        tbl[3]  = mk(1, 0, 1, 0, 0, 26'd40, 32'd0,         32'd0,  0, '0, 32'd0,  32'hA0, 0);
        tbl[4]  = mk(1, 0, 2, 0, 0, 26'd0,  32'd0,         32'd16, 0, '0, 32'd0,  32'h10, 0);
        tbl[5]  = mk(1, 0, 3, 0, 1, 26'd0,  32'hFFFF_FFFE, 32'd0,  0, '0, 32'd0,  32'h0C, 0);
        tbl[6]  = mk(1, 0, 2, 0, 0, 26'd0,  32'd0,         32'd16, 0, '0, 32'd0,  32'h10, 0);
        tbl[7]  = mk(1, 0, 3, 0, 0, 26'd0,  32'hFFFF_FFFE, 32'd0,  0, '0, 32'd0,  32'h14, 0);
        tbl[8]  = mk(1, 0, 2, 0, 0, 26'd0,  32'd0,         32'd16, 0, '0, 32'd0,  32'h10, 0);
        tbl[9]  = mk(1, 0, 3, 1, 0, 26'd0,  32'hFFFF_FFFE, 32'd0,  0, '0, 32'd0,  32'h0C, 0);
        tbl[10] = mk(1, 0, 2, 0, 0, 26'd0,  32'd0,         32'd16, 0, '0, 32'd0,  32'h10, 0);
        tbl[11] = mk(1, 0, 3, 1, 1, 26'd0,  32'hFFFF_FFFE, 32'd0,  0, '0, 32'd0,  32'h14, 0);
        tbl[12] = mk(1, 1, 1, 0, 0, 26'd40, 32'd0,         32'd0,  0, '0, 32'd0,  32'h14, 0);
        tbl[13] = mk(1, 1, 1, 0, 0, 26'd40, 32'd0,         32'd0,  0, '0, 32'd0,  32'h14, 0);
        tbl[14] = mk(1, 1, 1, 0, 0, 26'd40, 32'd0,         32'd0,  0, '0, 32'd0,  32'h14, 0);
        tbl[15] = mk(1, 0, 1, 0, 0, 26'd40, 32'd0,         32'd0,  0, '0, 32'd0,  32'hA0, 0);
        tbl[16] = mk(1, 0, 2, 0, 0, 26'd0,  32'd0,         32'd6,  0, '0, 32'd0,  32'hA0, 1);
        tbl[17] = mk(1, 0, 0, 0, 0, 26'd0,  32'd0,         32'd0,  0, '0, 32'd0,  32'hA0, 1);
        tbl[18] = mk(1, 1, 2, 0, 0, 26'd0,  32'd0,         32'd0,  0, '0, 32'd0,  32'hA0, 1);
        tbl[19] = mk(0, 1, 3, 0, 1, 26'd0,  32'd0,         32'd0,  1, '0, 32'h20, 32'h00, 0);

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i]);
        end

        // Write to the word being fetched: old word before the edge, new after.
        drive(mk(1, 1, 0, 0, 0, 26'd0, 32'd0, 32'd0, 1, '0, 32'h1234_5678, 32'h0, 0));
        #1;
        n_vec++;
        cmp("instr_pre_write", bus.instr, 32'h0000_0020);
        apply(mk(1, 1, 0, 0, 0, 26'd0, 32'd0, 32'd0, 1, '0, 32'h1234_5678, 32'h0, 0));

        // End-of-memory halt, then reset while stalled with a branch pending.
        apply(mk(1, 0, 2, 0, 0, 26'd0,  32'd0, 32'h0FFC, 0, '0, 32'd0, 32'h0FFC, 0));
        apply(mk(1, 0, 0, 0, 0, 26'd0,  32'd0, 32'd0,    0, '0, 32'd0, 32'h0FFC, 1));
        apply(mk(1, 0, 1, 0, 0, 26'd40, 32'd0, 32'd0,    0, '0, 32'd0, 32'h0FFC, 1));
        apply(mk(1, 1, 2, 0, 0, 26'd0,  32'd0, 32'h10,   0, '0, 32'd0, 32'h0FFC, 1));
        apply(mk(0, 1, 3, 0, 1, 26'd0,  32'd4, 32'd0,    0, '0, 32'd0, 32'h0000, 0));
        apply(mk(1, 0, 0, 0, 0, 26'd0,  32'd0, 32'd0,    0, '0, 32'd0, 32'h0004, 0));
        apply(mk(0, 1, 1, 0, 0, 26'd40, 32'd0, 32'd0,    0, '0, 32'd0, 32'h0000, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
